exec_ctl_p: RTL and testbench
=============================

Name: exec_ctl_p

Overview:
- Parametrised successor to the GPU/DSP instruction execution controller.
- Sequences prefetched instruction words into execution and gates `exe` on an N-way wait vector.
- Collects multi-word immediates with a configurable word count.
- Supports multi-instruction single-stepping via a step counter, and inserts the one-cycle compare-store interlock.
- Sits between the prefetch queue and the ALU/load-store control in the RISC core.

Parameters:
- IMM_WORDS, 2: number of 16-bit immediate words following an immld instruction (1..4).
- N_WAIT, 3: number of independent stall sources (scoreboard, matrix, etc.).
- STEP_W, 8: width of the single-step instruction counter.

Ports:
- sys_clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- go  in  1  run enable; low forces IDLE.
- insrdy  in  1  prefetch word valid this cycle.
- immld  in  1  current instruction carries an immediate.
- wait_req  in  N_WAIT  stall sources, OR-reduced.
- memrw  in  1  instruction is a memory op.
- datwe  in  1  memory op is a write.
- precomp  in  1  write requires compare-store interlock.
- single_step  in  1  step mode enable.
- single_go  in  1  one-cycle release from STOP.
- step_count  in  STEP_W  instructions per single_go; 0 treated as 1.
- exe  out  1  instruction executes this cycle.
- insexe  out  1  exe delayed one cycle (registered).
- romold  out  1  accept current prefetch word.
- immwri  out  1  immediate word written this cycle.
- imm_idx  out  $clog2(IMM_WORDS)+1  index of the immediate word being written.
- idle  out  1  state==IDLE.
- stop  out  1  state==STOP.
- compdwait  out  1  compare-store interlock active.
- dstdgate  out  1  data store gate.
- steps_left  out  STEP_W  remaining steps.

Behaviour:
- State machine: IDLE, EXEC, IMM, STOP.
- Registers: vins (instruction valid), imm_cnt, steps_left, compdwait, insexe.
- Reset values: state=IDLE, vins=0, imm_cnt=0, steps_left=0, compdwait=0, insexe=0. Consequently idle=1 and every other output is 0.
- exe = (state==EXEC) & vins & ~|wait_req & ~compdwait. Purely combinational; no latency.
- fire_last = exe & ~immld & single_step & steps_left==1.
- romold = insrdy & [ (state==EXEC & (~vins | exe) & ~(exe & immld) & ~fire_last) | state==IMM ].
- vins next:
  - Set when romold in EXEC.
  - Cleared on exe without a same-cycle romold.
  - Cleared on any transition to IMM, STOP or IDLE.
  - Held otherwise, including during wait.
  - exe and romold in the same cycle gives back-to-back execution with vins staying 1.
- IDLE -> EXEC when go=1; vins=0 on entry.
- EXEC -> IMM on exe & immld; imm_cnt=0.
- EXEC -> STOP on fire_last.
- IMM behaviour:
  - Each insrdy cycle: immwri=1, imm_idx=imm_cnt, then imm_cnt++.
  - When imm_cnt==IMM_WORDS-1 and insrdy, next state is EXEC. If single_step and steps_left==1, next state is STOP instead.
  - No insrdy: immwri=0 and the state is held; there is no timeout.
- STOP -> EXEC on single_go & go. steps_left loads max(step_count,1). vins=0; the first fetch follows.
- Step counting:
  - steps_left decrements on each completed instruction: exe without immld, or IMM completion.
  - It decrements only when single_step=1 and steps_left>0.
  - When single_step=0, steps_left is held at 0.
  - single_step asserted while running: stop after the instruction currently completing (steps_left is treated as 1).
- go=0 in any state -> IDLE next cycle:
  - vins=0; any partially written immediate is abandoned (imm_cnt=0).
  - exe is still evaluated in the same cycle.
  - go has priority over all other transitions.
- Compare-store interlock:
  - compdwait next = exe & memrw & datwe & precomp. It is a one-cycle pulse that blocks exe.
  - dstdgate = (exe & memrw & datwe & ~precomp) | compdwait.
- insexe next = exe.
- reset mid-operation has priority over go and everything else.
- imm_idx is valid only when immwri=1; otherwise it reads 0.

Decomposition:
- Package exec_ctl_pkg holds:
  - the state enum (IDLE, EXEC, IMM, STOP);
  - the IMM_IDX_W function;
  - the default constants IMM_WORDS_DEF and N_WAIT_DEF.
- One natural sub-module: exec_step_cnt (load/decrement/hold counter with an "==1" flag), reusable by the DSP controller.
- The remainder stays flat.

Test Plan:
- Run: reset, go=1, insrdy=1 continuously, no immld -> romold the first cycle after EXEC entry, then exe=1 every cycle from the 2nd EXEC cycle, insexe trailing by 1.
- Immediate: IMM_WORDS=3, exe with immld, insrdy toggles 1,0,1,1 -> immwri pulses with imm_idx 0,1,2 over 4 cycles, then EXEC with vins=0 and the next romold.
- Wait: wait_req=3'b010 held 3 cycles while vins=1 -> exe=0 and romold=0 for 3 cycles, vins stays 1, then exe=1 on release.
- Compare-store: exe with memrw=datwe=precomp=1 -> compdwait=1 and dstdgate=1 next cycle, exe blocked that cycle, resumes the cycle after; with precomp=0 -> dstdgate=1 in the exe cycle, no wait.
- Single step: STOP, step_count=2, single_go pulse -> exactly two exe pulses; no romold on the 2nd exe; stop=1 and steps_left=0. With step_count=0 -> exactly one exe.
- Abort: go=0 while in IMM with imm_cnt=1 -> IDLE next cycle, immwri=0, vins=0; go=1 -> EXEC, with a fresh fetch and imm_cnt=0.

Source files
------------

// File: rtl/exec_ctl_pkg.sv
// Shared types and constants for the instruction execution controller family.
package exec_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_IMM  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam int IMM_WORDS_DEF = 2;
    localparam int N_WAIT_DEF    = 3;

    // One extra bit so a single-word immediate still gets a 1-bit index.
    function automatic int IMM_IDX_W(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/exec_step_cnt.sv
// Single-step counter: load (0 loads as 1), decrement toward 0, or clear; flags ==1 and ==0.
module exec_step_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_eq1,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_load_val == '0) ? W'(1) : i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_eq1  = (r_cnt == W'(1));
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/exec_ctl_p.sv
// Execution controller: sequences prefetch words into exe, gathers multi-word
// immediates, single-steps by instruction count and inserts the compare-store bubble.
module exec_ctl_p
    import exec_ctl_pkg::*;
#(
    parameter int IMM_WORDS = IMM_WORDS_DEF,
    parameter int N_WAIT    = N_WAIT_DEF,
    parameter int STEP_W    = 8
) (
    input  logic                              sys_clk,
    input  logic                              reset,
    input  logic                              go,
    input  logic                              insrdy,
    input  logic                              immld,
    input  logic [N_WAIT-1:0]                 wait_req,
    input  logic                              memrw,
    input  logic                              datwe,
    input  logic                              precomp,
    input  logic                              single_step,
    input  logic                              single_go,
    input  logic [STEP_W-1:0]                 step_count,
    output logic                              exe,
    output logic                              insexe,
    output logic                              romold,
    output logic                              immwri,
    output logic [IMM_IDX_W(IMM_WORDS)-1:0]   imm_idx,
    output logic                              idle,
    output logic                              stop,
    output logic                              compdwait,
    output logic                              dstdgate,
    output logic [STEP_W-1:0]                 steps_left
);

    localparam int             IW       = IMM_IDX_W(IMM_WORDS);
    localparam logic [IW-1:0]  IMM_LAST = IW'(IMM_WORDS - 1);

    state_t         r_state;
    state_t         w_nxt;
    logic           r_vins;
    logic [IW-1:0]  r_imm_cnt;
    logic           r_compdwait;
    logic           r_insexe;

    logic           w_exe, w_romold, w_fire_last, w_imm_done, w_complete;
    logic           w_last_step, w_steps_eq1, w_steps_zero, w_vins_nxt;
    logic [IW-1:0]  w_imm_cnt_nxt;

    // A zero count while stepping means step mode was just enabled: stop after this one.
    assign w_last_step = single_step & (w_steps_eq1 | w_steps_zero);
    assign w_exe       = (r_state == ST_EXEC) & r_vins & ~(|wait_req) & ~r_compdwait;
    assign w_fire_last = w_exe & ~immld & w_last_step;
    assign w_imm_done  = (r_state == ST_IMM) & insrdy & (r_imm_cnt == IMM_LAST);
    assign w_complete  = (w_exe & ~immld) | w_imm_done;
    assign w_romold    = insrdy & (((r_state == ST_EXEC) & (~r_vins | w_exe)
                                    & ~(w_exe & immld) & ~w_fire_last)
                                   | (r_state == ST_IMM));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: w_nxt = ST_EXEC;
            ST_EXEC: begin
                if (w_exe && immld)   w_nxt = ST_IMM;
                else if (w_fire_last) w_nxt = ST_STOP;
            end
            ST_IMM: begin
                if (w_imm_done) w_nxt = w_last_step ? ST_STOP : ST_EXEC;
            end
            ST_STOP: begin
                if (single_go) w_nxt = ST_EXEC;
            end
            default: w_nxt = ST_IDLE;
        endcase
        if (!go) w_nxt = ST_IDLE;
    end

    // Fetch and execute in one cycle keeps vins high for back-to-back issue.
    assign w_vins_nxt    = (r_state == ST_EXEC && w_nxt == ST_EXEC) ?
                           (w_romold | (r_vins & ~w_exe)) : 1'b0;
    assign w_imm_cnt_nxt = (r_state == ST_IMM && w_nxt == ST_IMM) ?
                           (r_imm_cnt + IW'(insrdy)) : '0;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_vins      <= 1'b0;
            r_imm_cnt   <= '0;
            r_compdwait <= 1'b0;
            r_insexe    <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_vins      <= w_vins_nxt;
            r_imm_cnt   <= w_imm_cnt_nxt;
            r_compdwait <= w_exe & memrw & datwe & precomp;
            r_insexe    <= w_exe;
        end
    end

    exec_step_cnt #(.W(STEP_W)) u_step_cnt (
        .clk        (sys_clk),
        .rst        (reset),
        .i_clr      (~single_step),
        .i_load     ((r_state == ST_STOP) & single_go & go),
        .i_load_val (step_count),
        .i_dec      (w_complete & single_step),
        .o_cnt      (steps_left),
        .o_eq1      (w_steps_eq1),
        .o_zero     (w_steps_zero)
    );

    assign exe       = w_exe;
    assign insexe    = r_insexe;
    assign romold    = w_romold;
    assign immwri    = (r_state == ST_IMM) & insrdy;
    assign imm_idx   = immwri ? r_imm_cnt : '0;
    assign idle      = (r_state == ST_IDLE);
    assign stop      = (r_state == ST_STOP);
    assign compdwait = r_compdwait;
    assign dstdgate  = (w_exe & memrw & datwe & ~precomp) | r_compdwait;

endmodule

// File: tb/tb_exec_ctl_p.sv
// Directed bench for exec_ctl_p (IMM_WORDS=3, N_WAIT=3, STEP_W=8).
module tb_exec_ctl_p;

    logic       sys_clk, reset, go, insrdy, immld, memrw, datwe, precomp;
    logic       single_step, single_go;
    logic [2:0] wait_req;
    logic [7:0] step_count;
    logic       exe, insexe, romold, immwri, idle, stop, compdwait, dstdgate;
    logic [2:0] imm_idx;
    logic [7:0] steps_left;

    int n_cmp = 0;
    int n_bad = 0;

    exec_ctl_p #(.IMM_WORDS(3), .N_WAIT(3), .STEP_W(8)) dut (
        .sys_clk(sys_clk), .reset(reset), .go(go), .insrdy(insrdy), .immld(immld),
        .wait_req(wait_req), .memrw(memrw), .datwe(datwe), .precomp(precomp),
        .single_step(single_step), .single_go(single_go), .step_count(step_count),
        .exe(exe), .insexe(insexe), .romold(romold), .immwri(immwri), .imm_idx(imm_idx),
        .idle(idle), .stop(stop), .compdwait(compdwait), .dstdgate(dstdgate),
        .steps_left(steps_left)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; insrdy = 1'b0; immld = 1'b0; memrw = 1'b0;
        datwe = 1'b0; precomp = 1'b0; single_step = 1'b0; single_go = 1'b0;
        wait_req = 3'b000; step_count = 8'd0;
        tick(); tick();

        // reset state
        chk("rst_idle", idle, 1'b1);
        chk("rst_stop", stop, 1'b0);
        chk("rst_exe", exe, 1'b0);
        chk("rst_insexe", insexe, 1'b0);
        chk("rst_romold", romold, 1'b0);
        chk("rst_immwri", immwri, 1'b0);
        chk3("rst_imm_idx", imm_idx, 3'd0);
        chk("rst_compdwait", compdwait, 1'b0);
        chk("rst_dstdgate", dstdgate, 1'b0);
        chk8("rst_steps", steps_left, 8'd0);

        // run: first EXEC cycle fetches, exe from the second
        reset = 1'b0; go = 1'b1; insrdy = 1'b1;
        tick();
        chk("run0_idle", idle, 1'b0);
        chk("run0_romold", romold, 1'b1);
        chk("run0_exe", exe, 1'b0);
        tick();
        chk("run1_exe", exe, 1'b1);
        chk("run1_romold", romold, 1'b1);
        chk("run1_insexe", insexe, 1'b0);
        tick();
        chk("run2_exe", exe, 1'b1);
        chk("run2_insexe", insexe, 1'b1);

        // wait: three stalled cycles, vins held, exe on release
        wait_req = 3'b010; settle();
        chk("wait1_exe", exe, 1'b0);
        chk("wait1_romold", romold, 1'b0);
        tick();
        chk("wait2_exe", exe, 1'b0);
        chk("wait2_romold", romold, 1'b0);
        tick();
        chk("wait3_exe", exe, 1'b0);
        chk("wait3_insexe", insexe, 1'b0);
        tick();
        wait_req = 3'b000; settle();
        chk("wait_rel_exe", exe, 1'b1);
        chk("wait_rel_romold", romold, 1'b1);

        // compare-store with interlock
        memrw = 1'b1; datwe = 1'b1; precomp = 1'b1; settle();
        chk("cs_exe", exe, 1'b1);
        chk("cs_dstd0", dstdgate, 1'b0);
        tick();
        memrw = 1'b0; datwe = 1'b0; precomp = 1'b0; settle();
        chk("cs_compdwait", compdwait, 1'b1);
        chk("cs_dstd1", dstdgate, 1'b1);
        chk("cs_blocked", exe, 1'b0);
        chk("cs_blk_romold", romold, 1'b0);
        tick();
        chk("cs_cw_clear", compdwait, 1'b0);
        chk("cs_resume", exe, 1'b1);
        // plain store: gate in exe cycle, no bubble
        memrw = 1'b1; datwe = 1'b1; settle();
        chk("st_dstd", dstdgate, 1'b1);
        tick();
        memrw = 1'b0; datwe = 1'b0; settle();
        chk("st_no_cw", compdwait, 1'b0);
        chk("st_exe", exe, 1'b1);

        // immediate: 3 words, insrdy 1,0,1,1
        immld = 1'b1; settle();
        chk("imm_exe", exe, 1'b1);
        chk("imm_romold", romold, 1'b0);
        tick();
        immld = 1'b0; settle();
        chk("imm_w0", immwri, 1'b1);
        chk3("imm_idx0", imm_idx, 3'd0);
        chk("imm_exe_off", exe, 1'b0);
        tick();
        insrdy = 1'b0; settle();
        chk("imm_gap", immwri, 1'b0);
        chk3("imm_gap_idx", imm_idx, 3'd0);
        tick();
        insrdy = 1'b1; settle();
        chk("imm_w1", immwri, 1'b1);
        chk3("imm_idx1", imm_idx, 3'd1);
        tick();
        chk("imm_w2", immwri, 1'b1);
        chk3("imm_idx2", imm_idx, 3'd2);
        tick();
        chk("imm_back_immwri", immwri, 1'b0);
        chk("imm_back_exe", exe, 1'b0);
        chk("imm_back_romold", romold, 1'b1);
        tick();
        chk("imm_back_exe2", exe, 1'b1);

        // single_step raised while running: stop after this instruction
        single_step = 1'b1; settle();
        chk("ss_entry_exe", exe, 1'b1);
        chk("ss_entry_romold", romold, 1'b0);
        tick();
        chk("ss_stop", stop, 1'b1);
        chk("ss_stop_exe", exe, 1'b0);
        chk8("ss_stop_steps", steps_left, 8'd0);

        // step_count=2: exactly two exe pulses
        step_count = 8'd2; single_go = 1'b1;
        tick();
        single_go = 1'b0; settle();
        chk("s2_stop_off", stop, 1'b0);
        chk8("s2_load", steps_left, 8'd2);
        chk("s2_fetch", romold, 1'b1);
        chk("s2_exe0", exe, 1'b0);
        tick();
        chk("s2_exe1", exe, 1'b1);
        chk("s2_romold1", romold, 1'b1);
        tick();
        chk8("s2_steps1", steps_left, 8'd1);
        chk("s2_exe2", exe, 1'b1);
        chk("s2_romold2", romold, 1'b0);
        tick();
        chk("s2_stop", stop, 1'b1);
        chk("s2_exe3", exe, 1'b0);
        chk8("s2_steps0", steps_left, 8'd0);

        // step_count=0 behaves as 1
        step_count = 8'd0; single_go = 1'b1;
        tick();
        single_go = 1'b0; settle();
        chk8("s0_load", steps_left, 8'd1);
        chk("s0_fetch", romold, 1'b1);
        tick();
        chk("s0_exe", exe, 1'b1);
        chk("s0_romold", romold, 1'b0);
        tick();
        chk("s0_stop", stop, 1'b1);
        chk("s0_exe_off", exe, 1'b0);
        tick();
        chk("s0_still_stop", stop, 1'b1);

        // abort mid-immediate
        single_step = 1'b0; single_go = 1'b1;
        tick();
        single_go = 1'b0; settle();
        chk("ab_fetch", romold, 1'b1);
        tick();
        immld = 1'b1; settle();
        chk("ab_exe", exe, 1'b1);
        tick();
        immld = 1'b0; settle();
        chk3("ab_w0", imm_idx, 3'd0);
        tick();
        go = 1'b0; insrdy = 1'b0; settle();
        chk("ab_immwri_go0", immwri, 1'b0);
        tick();
        chk("ab_idle", idle, 1'b1);
        chk("ab_immwri", immwri, 1'b0);
        chk("ab_exe_idle", exe, 1'b0);
        chk("ab_romold_idle", romold, 1'b0);
        go = 1'b1; insrdy = 1'b1;
        tick();
        chk("ab_reexec_exe", exe, 1'b0);
        chk("ab_refetch", romold, 1'b1);
        tick();
        immld = 1'b1; settle();
        chk("ab_exe2", exe, 1'b1);
        tick();
        immld = 1'b0; settle();
        chk("ab_fresh_immwri", immwri, 1'b1);
        chk3("ab_fresh_idx", imm_idx, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
